// File: rtl/timed_event_pkg.sv
// Shared types and default widths for the timed event scheduler.
// Events are (timestamp, payload) pairs released against the global counter.
package timed_event_pkg;

  localparam int DEF_TS_WIDTH   = 64;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_FIFO_ADDR  = 4;
  localparam int DEF_LATE_TOL   = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ARMED
  } state_t;

  typedef struct packed {
    logic [DEF_TS_WIDTH-1:0]   ts;
    logic [DEF_DATA_WIDTH-1:0] data;
  } event_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with registered read data; flush has priority over push/pop.
// The read register doubles as the scheduler's head-of-queue event.
module event_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16,
  parameter int ADDR  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [ADDR:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR-1:0]  wr_ptr_reg;
  logic [ADDR-1:0]  rd_ptr_reg;
  logic [ADDR:0]    count_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (ADDR+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_data_reg <= mem[rd_ptr_reg];
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (ADDR+1)'(1);
        2'b01:   count_reg <= count_reg - (ADDR+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = rd_data_reg;
  assign count   = count_reg;

endmodule

// File: rtl/timed_event_scheduler.sv
// Buffers timestamped events and strobes each one out once the global counter
// reaches its timestamp, flagging releases later than LATE_TOL.
module timed_event_scheduler
  import timed_event_pkg::*;
#(
  parameter int TS_WIDTH   = DEF_TS_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int FIFO_ADDR  = DEF_FIFO_ADDR,
  parameter int LATE_TOL   = DEF_LATE_TOL
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  auto_start,
  input  logic [TS_WIDTH-1:0]   counter,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TS_WIDTH-1:0]   in_timestamp,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  flush,
  input  logic                  clear_error,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TS_WIDTH-1:0]   out_timestamp,
  output logic                  late_error,
  output logic [FIFO_ADDR:0]    fifo_count,
  output logic                  busy
);

  localparam int EV_WIDTH = TS_WIDTH + DATA_WIDTH;

  state_t                state_reg, state_next;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [EV_WIDTH-1:0]   head_ev;
  logic [TS_WIDTH-1:0]   head_ts;
  logic [DATA_WIDTH-1:0] head_data;
  logic [TS_WIDTH-1:0]   lateness;
  logic                  release_hit;
  logic                  release_now;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [TS_WIDTH-1:0]   out_ts_reg;
  logic                  late_reg;

  assign in_ready = !fifo_full;

  event_fifo #(
    .WIDTH (EV_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .ADDR  (FIFO_ADDR)
  ) u_fifo (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .push    (in_valid && in_ready),
    .pop     (fifo_pop),
    .flush   (flush),
    .wr_data ({in_timestamp, in_data}),
    .rd_data (head_ev),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The FIFO read register is the head event; it is valid from LOAD onward.
  assign head_ts     = head_ev[EV_WIDTH-1:DATA_WIDTH];
  assign head_data   = head_ev[DATA_WIDTH-1:0];
  assign release_hit = auto_start && (counter >= head_ts);
  assign lateness    = counter - head_ts;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    fifo_pop    = 1'b0;
    release_now = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            state_next = LOAD;
          end
        end
        LOAD: state_next = ARMED;
        ARMED: begin
          if (release_hit) begin
            release_now = 1'b1;
            if (!fifo_empty) begin
              fifo_pop   = 1'b1;
              state_next = LOAD;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ts_reg    <= '0;
      late_reg      <= 1'b0;
    end else begin
      out_valid_reg <= release_now;
      if (release_now) begin
        out_data_reg <= head_data;
        out_ts_reg   <= head_ts;
      end
      // A late release in the same cycle as clear_error keeps the flag set.
      if (release_now && (lateness > TS_WIDTH'(LATE_TOL))) begin
        late_reg <= 1'b1;
      end else if (clear_error) begin
        late_reg <= 1'b0;
      end
    end
  end

  assign out_valid     = out_valid_reg;
  assign out_data      = out_data_reg;
  assign out_timestamp = out_ts_reg;
  assign late_error    = late_reg;
  assign busy          = (fifo_count != '0) || (state_reg != IDLE);

endmodule
